// File: rtl/mul_arb_pkg.sv
// Shared types and widths for the multiplier-sharing arbiter.
package mul_arb_pkg;

  localparam int MUL_W       = 32;
  localparam int PROD_W      = 64;
  localparam int DEF_TIMEOUT = 40;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    START,
    WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/mul_share_arbiter_if.sv
// Requester and multiplier signals of the arbiter. The slave modport is the arbiter's
// view; master is the surrounding requesters plus the multiplier.
interface mul_share_arbiter_if
  import mul_arb_pkg::*;
#(
  parameter int N_REQ = 2
) ();

  logic [N_REQ-1:0]       req;
  logic [N_REQ*MUL_W-1:0] opa;
  logic [N_REQ*MUL_W-1:0] opb;
  logic [N_REQ-1:0]       rsp_valid;
  logic [PROD_W-1:0]      rsp_product;
  logic                   rsp_err;
  logic                   busy;
  logic [MUL_W-1:0]       mul_mcand;
  logic [MUL_W-1:0]       mul_mplier;
  logic                   mul_run;
  logic                   mul_reset;
  logic                   mul_ready;
  logic [PROD_W-1:0]      mul_product;

  modport slave (
    input  req, opa, opb, mul_ready, mul_product,
    output rsp_valid, rsp_product, rsp_err, busy,
           mul_mcand, mul_mplier, mul_run, mul_reset
  );

  modport master (
    output req, opa, opb, mul_ready, mul_product,
    input  rsp_valid, rsp_product, rsp_err, busy,
           mul_mcand, mul_mplier, mul_run, mul_reset
  );

endinterface

// File: rtl/mul_share_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic             o_valid,
  output logic [ID_W-1:0]  o_id
);

  // Outer loop runs from the farthest offset down, so the nearest hit is written last.
  always_comb begin
    o_valid = 1'b0;
    o_id    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (i_req[i] && (i == ((int'(i_ptr) + k) % N_REQ))) begin
          o_valid = 1'b1;
          o_id    = ID_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one sequential shift-add multiplier between N_REQ requesters with round-robin
// grant, clear/run sequencing, a WAIT watchdog and a one-hot completion pulse.
//
//   state | meaning
//   IDLE  | multiplier released, waiting for any request
//   CLEAR | mul_reset high for one cycle, operands already latched
//   START | mul_run high for one cycle, stale mul_ready ignored
//   WAIT  | counting until mul_ready or watchdog expiry
//   DONE  | rsp_valid pulse to the granted requester
module mul_share_arbiter
  import mul_arb_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic                clk,
  input logic                rst,
  mul_share_arbiter_if.slave bus
);

  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam int                ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0]  ONE_HOT0 = N_REQ'(1);
  localparam logic [ID_W-1:0]   LAST_ID  = ID_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TIMEOUT);

  state_t              r_state;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     r_id;
  logic [CNT_W-1:0]    r_cnt;
  logic [MUL_W-1:0]    r_mcand;
  logic [MUL_W-1:0]    r_mplier;
  logic                r_run;
  logic                r_mreset;
  logic                r_busy;
  logic [N_REQ-1:0]    r_rsp_valid;
  logic [PROD_W-1:0]   r_rsp_product;
  logic                r_rsp_err;

  logic                w_valid;
  logic [ID_W-1:0]     w_id;
  logic [N_REQ-1:0]    w_onehot;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_valid (w_valid),
    .o_id    (w_id)
  );

  assign w_onehot = ONE_HOT0 << r_id;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_id          <= '0;
      r_cnt         <= '0;
      r_mcand       <= '0;
      r_mplier      <= '0;
      r_run         <= 1'b0;
      r_mreset      <= 1'b1;
      r_busy        <= 1'b0;
      r_rsp_valid   <= '0;
      r_rsp_product <= '0;
      r_rsp_err     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_id     <= w_id;
            r_mcand  <= bus.opa[w_id*MUL_W +: MUL_W];
            r_mplier <= bus.opb[w_id*MUL_W +: MUL_W];
            r_mreset <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= CLEAR;
          end else begin
            r_mreset <= 1'b0;
          end
        end
        CLEAR: begin
          r_mreset <= 1'b0;
          r_run    <= 1'b1;
          r_state  <= START;
        end
        START: begin
          r_run   <= 1'b0;
          r_cnt   <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          // Ready wins over the watchdog when both land in the same cycle.
          if (bus.mul_ready) begin
            r_rsp_valid   <= w_onehot;
            r_rsp_product <= bus.mul_product;
            r_rsp_err     <= 1'b0;
            r_state       <= DONE;
          end else if (r_cnt == CNT_MAX) begin
            r_rsp_valid   <= w_onehot;
            r_rsp_product <= '0;
            r_rsp_err     <= 1'b1;
            r_mreset      <= 1'b1;
            r_state       <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_rsp_valid   <= '0;
          r_rsp_product <= '0;
          r_rsp_err     <= 1'b0;
          r_mreset      <= 1'b0;
          r_busy        <= 1'b0;
          r_ptr         <= (r_id == LAST_ID) ? '0 : r_id + 1'b1;
          r_state       <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_product = r_rsp_product;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.busy        = r_busy;
  assign bus.mul_mcand   = r_mcand;
  assign bus.mul_mplier  = r_mplier;
  assign bus.mul_run     = r_run;
  assign bus.mul_reset   = r_mreset;

endmodule
